// File: rtl/seg7_scan_disp.sv
`default_nettype none
// ============================================================================
// seg7_scan_disp : N-digit seven-segment controller (static or scanned) with
//                  sign glyph, blink and tear-free valid/ready load.
//                  Optional macro DISP_DP_EN adds per-digit decimal points.
// Revision : 1.0
// ============================================================================
module seg7_scan_disp #(
  parameter int N_DIGITS    = 4,
  parameter int B_W         = 9,
  parameter int MUX_MODE    = 0,
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [4*(N_DIGITS-1)-1:0] i_bcd,
  input  logic [3:0]                i_sign,
  input  logic [B_W-1:0]            i_b_val,
`ifdef DISP_DP_EN
  input  logic [N_DIGITS-2:0]       i_dp,
  output logic [8*N_DIGITS-1:0]     out_seg,
  output logic [7:0]                o_seg,
`else
  output logic [7*N_DIGITS-1:0]     out_seg,
  output logic [6:0]                o_seg,
`endif
  input  logic                      i_blink,
  output logic [B_W-1:0]            o_b_val,
  output logic [N_DIGITS-1:0]       o_an
);

`ifdef DISP_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif
  localparam int ND = N_DIGITS - 1;
  localparam int SW = $clog2(N_DIGITS);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  function automatic logic [6:0] dig7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] sign7(input logic [3:0] s);
    case (s)
      4'hD:    return 7'b0111111;
      4'hC:    return 7'b1111111;
      default: return 7'b0001000;
    endcase
  endfunction

  // Pending buffer and active register
  logic                pend_full_q, pend_full_d;
  logic [4*ND-1:0]     pend_bcd_q, pend_bcd_d, act_bcd_q, act_bcd_d;
  logic [3:0]          pend_sign_q, pend_sign_d, act_sign_q, act_sign_d;
  logic [B_W-1:0]      pend_b_q, pend_b_d, act_b_q, act_b_d;
`ifdef DISP_DP_EN
  logic [ND-1:0]       pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
`endif
  logic [PW-1:0]       presc_q, presc_d;
  logic [SW-1:0]       scan_q, scan_d;
  logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                phase_q, phase_d;
  logic [SEG_W*N_DIGITS-1:0] out_seg_q, out_seg_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic                tick, accept, commit, blank;
  logic [SW-1:0]       k;
  logic [SEG_W-1:0]    sign_g;
  logic [SEG_W-1:0]    dig   [N_DIGITS];
  logic [SEG_W-1:0]    glyph [N_DIGITS];

  always_comb begin
    tick   = (presc_q == PW'(SCAN_DIV - 1));
    accept = i_valid & ~pend_full_q;
    if (MUX_MODE == 0) commit = pend_full_q;
    else               commit = pend_full_q & tick & (scan_q == SW'(N_DIGITS - 1));
    blank  = i_blink & phase_q;
  end

  always_comb begin
    pend_full_d = pend_full_q;
    pend_bcd_d  = pend_bcd_q;
    pend_sign_d = pend_sign_q;
    pend_b_d    = pend_b_q;
    act_bcd_d   = act_bcd_q;
    act_sign_d  = act_sign_q;
    act_b_d     = act_b_q;
`ifdef DISP_DP_EN
    pend_dp_d   = pend_dp_q;
    act_dp_d    = act_dp_q;
`endif
    if (accept) begin
      pend_full_d = 1'b1;
      pend_bcd_d  = i_bcd;
      pend_sign_d = i_sign;
      pend_b_d    = i_b_val;
`ifdef DISP_DP_EN
      pend_dp_d   = i_dp;
`endif
    end else if (commit) begin
      pend_full_d = 1'b0;
    end
    if (commit) begin
      act_bcd_d  = pend_bcd_q;
      act_sign_d = pend_sign_q;
      act_b_d    = pend_b_q;
`ifdef DISP_DP_EN
      act_dp_d   = pend_dp_q;
`endif
    end
  end

  always_comb begin
    presc_d     = tick ? '0 : presc_q + 1'b1;
    scan_d      = scan_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (tick) begin
      scan_d = (scan_q == SW'(N_DIGITS - 1)) ? '0 : scan_q + 1'b1;
      if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // k = most significant nonzero digit; the sign floats just above it
  always_comb begin
    k = '0;
    for (int i = 0; i < ND; i++)
      if (act_bcd_q[4*i +: 4] != 4'd0) k = SW'(i);
    for (int p = 0; p < N_DIGITS; p++) dig[p] = '1;
    for (int i = 0; i < ND; i++) begin
`ifdef DISP_DP_EN
      dig[i] = {~act_dp_q[i], dig7(act_bcd_q[4*i +: 4])};
`else
      dig[i] = dig7(act_bcd_q[4*i +: 4]);
`endif
    end
`ifdef DISP_DP_EN
    sign_g = {1'b1, sign7(act_sign_q)};
`else
    sign_g = sign7(act_sign_q);
`endif
    for (int p = 0; p < N_DIGITS; p++) begin
      if (SW'(p) <= k)               glyph[p] = dig[p];
      else if (SW'(p) == k + 1'b1)   glyph[p] = sign_g;
      else                           glyph[p] = '1;
    end
  end

  always_comb begin
    out_seg_d = '1;
    seg_d     = '1;
    an_d      = '1;
    if (MUX_MODE == 0) begin
      if (!blank)
        for (int p = 0; p < N_DIGITS; p++) out_seg_d[SEG_W*p +: SEG_W] = glyph[p];
    end else begin
      if (!blank) seg_d = glyph[scan_q];
      an_d[scan_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pend_full_q <= 1'b0;
      pend_bcd_q  <= '0;
      pend_sign_q <= 4'hC;
      pend_b_q    <= '0;
      act_bcd_q   <= '0;
      act_sign_q  <= 4'hC;
      act_b_q     <= '0;
`ifdef DISP_DP_EN
      pend_dp_q   <= '0;
      act_dp_q    <= '0;
`endif
      presc_q     <= '0;
      scan_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      out_seg_q   <= '1;
      seg_q       <= '1;
      an_q        <= '1;
    end else begin
      pend_full_q <= pend_full_d;
      pend_bcd_q  <= pend_bcd_d;
      pend_sign_q <= pend_sign_d;
      pend_b_q    <= pend_b_d;
      act_bcd_q   <= act_bcd_d;
      act_sign_q  <= act_sign_d;
      act_b_q     <= act_b_d;
`ifdef DISP_DP_EN
      pend_dp_q   <= pend_dp_d;
      act_dp_q    <= act_dp_d;
`endif
      presc_q     <= presc_d;
      scan_q      <= scan_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      out_seg_q   <= out_seg_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign o_ready = ~pend_full_q;
  assign o_b_val = act_b_q;
  assign out_seg = out_seg_q;
  assign o_seg   = seg_q;
  assign o_an    = an_q;

endmodule
`default_nettype wire
